// File: rtl/operand_fetch_sequencer_if.sv
// Handshake bundle between the operand fetch sequencer and its neighbours:
// fetch-unit start, instruction-memory read port, accumulator put strobe and command handshake.
interface operand_fetch_sequencer_if #(
    parameter int ADDR_W = 8
);
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [1:0]        op_count;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [7:0]        mem_data;
    logic              put_flag;
    logic [7:0]        put_value;
    logic [1:0]        ops_loaded;
    logic              cmd_valid;
    logic              cmd_ack;
    logic              busy;
    logic [ADDR_W-1:0] next_addr;
    logic              err;

    modport master (
        input  start, base_addr, op_count, mem_ack, mem_data, cmd_ack,
        output mem_req, mem_addr, put_flag, put_value, ops_loaded,
               cmd_valid, busy, next_addr, err
    );

    modport slave (
        output start, base_addr, op_count, mem_ack, mem_data, cmd_ack,
        input  mem_req, mem_addr, put_flag, put_value, ops_loaded,
               cmd_valid, busy, next_addr, err
    );
endinterface

// File: rtl/operand_fetch_sequencer.sv
// Fetches up to MAX_OPS operand bytes into the accumulator one put per byte,
// inserts a settle cycle, then holds cmd_valid until the consumer acks.
module operand_fetch_sequencer #(
    parameter int ADDR_W  = 8,
    parameter int MAX_OPS = 3
) (
    input logic                       clk,
    input logic                       rst_n,
    operand_fetch_sequencer_if.master bus
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_REQ    = 3'd1;
    localparam logic [2:0] S_PUT    = 3'd2;
    localparam logic [2:0] S_SETTLE = 3'd3;
    localparam logic [2:0] S_CMD    = 3'd4;

    localparam logic [2:0] MAX_CNT = 3'(MAX_OPS);

    logic [2:0]        state;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] next_addr;
    logic [1:0]        count;
    logic [1:0]        loaded;
    logic [1:0]        loaded_inc;
    logic [7:0]        data;
    logic              err;

    assign loaded_inc = loaded + 2'd1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            addr      <= '0;
            next_addr <= '0;
            count     <= 2'd0;
            loaded    <= 2'd0;
            data      <= 8'd0;
            err       <= 1'b0;
        end else begin
            err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        if ({1'b0, bus.op_count} > MAX_CNT) begin
                            err <= 1'b1;
                        end else begin
                            // A zero-operand command still records its base so next_addr
                            // reports where the (empty) operand run ended.
                            addr   <= bus.base_addr;
                            count  <= bus.op_count;
                            loaded <= 2'd0;
                            state  <= (bus.op_count == 2'd0) ? S_SETTLE : S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (bus.mem_ack) begin
                        data  <= bus.mem_data;
                        state <= S_PUT;
                    end
                end
                S_PUT: begin
                    loaded <= loaded_inc;
                    addr   <= addr + ADDR_W'(1);
                    state  <= (loaded_inc == count) ? S_SETTLE : S_REQ;
                end
                S_SETTLE: state <= S_CMD;
                S_CMD: begin
                    if (bus.cmd_ack) begin
                        next_addr <= addr;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Every output is a decode of registered state, so no input reaches an output combinationally.
    assign bus.mem_req    = (state == S_REQ);
    assign bus.mem_addr   = addr;
    assign bus.put_flag   = (state == S_PUT);
    assign bus.put_value  = data;
    assign bus.ops_loaded = loaded;
    assign bus.cmd_valid  = (state == S_CMD);
    assign bus.busy       = (state != S_IDLE);
    assign bus.next_addr  = next_addr;
    assign bus.err        = err;
endmodule

// File: tb/tb_operand_fetch_sequencer.sv
// Directed bench: cycle-timeline model of the fetch sequence checked every cycle,
// plus literal expectations for the listed scenarios.
module tb_operand_fetch_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    operand_fetch_sequencer_if #(.ADDR_W(8)) bus ();
    operand_fetch_sequencer_if #(.ADDR_W(8)) bus2 ();

    operand_fetch_sequencer #(.ADDR_W(8), .MAX_OPS(3)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
    operand_fetch_sequencer #(.ADDR_W(8), .MAX_OPS(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit chk_en  = 1'b0;

    // Model: a sequence is fully described by its start cycle, count, wait and data.
    bit         m_active = 1'b0;
    int         m_t0, m_n, m_w;
    logic [7:0] m_base;
    logic [7:0] m_data [3];
    logic [7:0] m_idle_addr = 8'h00;
    logic [7:0] m_idle_next = 8'h00;
    logic [1:0] m_idle_loaded = 2'd0;

    int         put_rel_q[$];
    logic [7:0] put_val_q[$];
    logic [7:0] addr_q[$];
    int         cmd_rel;
    int         cmd_cnt;
    logic [7:0] acc [3];
    int         acc_idx;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin : cmp
        logic       e_req, e_put, e_cmd, e_busy;
        logic [7:0] e_addr, e_pv, e_next;
        logic [1:0] e_ld;
        int         rel, p, k, m, done;
        if (chk_en) begin
            e_req = 0; e_put = 0; e_cmd = 0; e_busy = 0; e_pv = 8'h00;
            e_addr = m_idle_addr; e_ld = m_idle_loaded; e_next = m_idle_next;
            if (m_active) begin
                rel = cyc - m_t0;
                if (rel >= 1) begin
                    p = rel - 1;
                    k = p / (m_w + 2);
                    m = p % (m_w + 2);
                    done = (k < m_n) ? k : m_n;
                    e_busy = 1;
                    e_req = (k < m_n) && (m <= m_w);
                    e_put = (k < m_n) && (m == m_w + 1);
                    if (e_put) e_pv = m_data[k];
                    e_addr = m_base + 8'(done);
                    e_ld = 2'(done);
                    e_cmd = (rel >= m_n * (m_w + 2) + 2);
                end
            end
            check("mem_req", bus.mem_req, e_req);
            check("mem_addr", bus.mem_addr, e_addr);
            check("put_flag", bus.put_flag, e_put);
            if (e_put) check("put_value", bus.put_value, e_pv);
            check("ops_loaded", bus.ops_loaded, e_ld);
            check("cmd_valid", bus.cmd_valid, e_cmd);
            check("busy", bus.busy, e_busy);
            check("next_addr", bus.next_addr, e_next);
            check("err", bus.err, 1'b0);

            if (bus.put_flag) begin
                put_rel_q.push_back(cyc - m_t0);
                put_val_q.push_back(bus.put_value);
                if (acc_idx < 3) acc[acc_idx] = bus.put_value;
                acc_idx++;
            end
            if (bus.mem_req && (addr_q.size() == 0 || addr_q[addr_q.size()-1] != bus.mem_addr))
                addr_q.push_back(bus.mem_addr);
            if (bus.cmd_valid) begin
                cmd_cnt++;
                if (cmd_rel < 0) cmd_rel = cyc - m_t0;
            end
        end
    end

    task automatic drive_idle();
        bus.start = 0; bus.base_addr = 8'h00; bus.op_count = 2'd0;
        bus.mem_ack = 0; bus.mem_data = 8'h00; bus.cmd_ack = 0;
        rst_n = 1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            drive_idle();
        end
    endtask

    // Memory acks on the w-th REQ cycle of each read; cmd_ack comes hold cycles after cmd_valid rises.
    task automatic run_seq(input logic [7:0] base, input int n, input int w,
                           input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                           input int hold, input bit spur, input int abort_rel);
        int ack_rel, p, k, m;
        ack_rel = n * (w + 2) + 2 + hold;
        put_rel_q.delete(); put_val_q.delete(); addr_q.delete();
        cmd_rel = -1; cmd_cnt = 0; acc_idx = 0;
        for (int rel = 0; rel <= ack_rel + 1; rel++) begin
            @(posedge clk); #1;
            drive_idle();
            if (rel == 0) begin
                m_t0 = cyc; m_n = n; m_w = w; m_base = base;
                m_data = '{d0, d1, d2};
                m_active = 1;
                bus.start = 1; bus.base_addr = base; bus.op_count = 2'(n);
            end else begin
                p = rel - 1;
                k = p / (w + 2);
                m = p % (w + 2);
                if (k < n && m == w) begin
                    bus.mem_ack = 1;
                    bus.mem_data = (k == 0) ? d0 : (k == 1) ? d1 : d2;
                end
                if (spur) begin
                    if (k < n && m == w + 1) begin
                        bus.mem_ack = 1; bus.mem_data = 8'hEE;
                    end
                    if (rel == 1) begin
                        bus.start = 1; bus.base_addr = 8'h55; bus.op_count = 2'd1; bus.cmd_ack = 1;
                    end
                end
                if (rel == ack_rel) bus.cmd_ack = 1;
            end
            if (abort_rel > 0 && rel == abort_rel) rst_n = 0;
            if (abort_rel > 0 && rel == abort_rel + 1) begin
                m_active = 0; m_idle_addr = 8'h00; m_idle_next = 8'h00; m_idle_loaded = 2'd0;
                break;
            end
            if (rel == ack_rel + 1) begin
                m_active = 0;
                m_idle_addr = base + 8'(n);
                m_idle_next = base + 8'(n);
                m_idle_loaded = 2'(n);
            end
        end
    endtask

    initial begin
        int         e_rel [3];
        logic [7:0] e_val [3];
        drive_idle();
        rst_n = 0;
        bus2.start = 0; bus2.base_addr = 8'h00; bus2.op_count = 2'd0;
        bus2.mem_ack = 0; bus2.mem_data = 8'h00; bus2.cmd_ack = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", bus.busy, 1'b0);
        check("rst_mem_addr", bus.mem_addr, 8'h00);
        check("rst_put_value", bus.put_value, 8'h00);
        chk_en = 1;
        rst_n = 1;
        idle(2);

        // basic fetch
        run_seq(8'h10, 3, 0, 8'hA1, 8'hB2, 8'hC3, 0, 0, 0);
        e_rel = '{2, 4, 6}; e_val = '{8'hA1, 8'hB2, 8'hC3};
        check("basic_puts", put_rel_q.size(), 3);
        for (int i = 0; i < 3 && i < put_rel_q.size(); i++) begin
            check("basic_put_cycle", put_rel_q[i], e_rel[i]);
            check("basic_put_value", put_val_q[i], e_val[i]);
            check("basic_acc_slot", acc[i], e_val[i]);
        end
        check("basic_cmd_cycle", cmd_rel, 8);
        check("basic_next_addr", bus.next_addr, 8'h13);
        idle(2);

        // memory wait states
        run_seq(8'h40, 2, 3, 8'h11, 8'h22, 8'h00, 0, 0, 0);
        check("wait_puts", put_rel_q.size(), 2);
        if (put_rel_q.size() == 2) begin
            check("wait_put0_cycle", put_rel_q[0], 5);
            check("wait_put1_cycle", put_rel_q[1], 10);
        end
        check("wait_cmd_cycle", cmd_rel, 12);
        idle(1);

        // zero count
        run_seq(8'h30, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0);
        check("zero_cmd_cycle", cmd_rel, 2);
        check("zero_puts", put_rel_q.size(), 0);
        check("zero_reqs", addr_q.size(), 0);
        idle(1);

        // illegal count on the MAX_OPS=2 instance
        @(posedge clk); #1;
        bus2.start = 1; bus2.op_count = 2'd3; bus2.base_addr = 8'h77;
        check("ill_err_pre", bus2.err, 1'b0);
        @(posedge clk); #1;
        bus2.start = 0; bus2.op_count = 2'd0; bus2.base_addr = 8'h00;
        check("ill_err", bus2.err, 1'b1);
        check("ill_busy", bus2.busy, 1'b0);
        check("ill_mem_req", bus2.mem_req, 1'b0);
        @(posedge clk); #1;
        check("ill_err_drop", bus2.err, 1'b0);
        check("ill_busy2", bus2.busy, 1'b0);
        check("ill_mem_addr", bus2.mem_addr, 8'h00);
        idle(1);

        // address wrap
        run_seq(8'hFE, 3, 0, 8'h05, 8'h06, 8'h07, 0, 0, 0);
        check("wrap_reqs", addr_q.size(), 3);
        if (addr_q.size() == 3) begin
            check("wrap_addr0", addr_q[0], 8'hFE);
            check("wrap_addr1", addr_q[1], 8'hFF);
            check("wrap_addr2", addr_q[2], 8'h00);
        end
        check("wrap_next_addr", bus.next_addr, 8'h01);
        idle(1);

        // backpressure with stray start, mem_ack in PUT and early cmd_ack
        run_seq(8'h80, 3, 1, 8'h01, 8'h02, 8'h03, 5, 1, 0);
        check("bp_cmd_cycles", cmd_cnt, 6);
        check("bp_cmd_cycle", cmd_rel, 11);
        e_val = '{8'h01, 8'h02, 8'h03};
        check("bp_puts", put_val_q.size(), 3);
        for (int i = 0; i < 3 && i < put_val_q.size(); i++)
            check("bp_put_value", put_val_q[i], e_val[i]);
        check("bp_next_addr", bus.next_addr, 8'h83);
        idle(1);

        // reset in the cycle after the first put
        run_seq(8'h20, 3, 0, 8'h31, 8'h32, 8'h33, 0, 0, 3);
        check("abort_busy", bus.busy, 1'b0);
        check("abort_put", bus.put_flag, 1'b0);
        check("abort_mem_req", bus.mem_req, 1'b0);
        check("abort_mem_addr", bus.mem_addr, 8'h00);
        check("abort_ops_loaded", bus.ops_loaded, 2'd0);
        check("abort_put_value", bus.put_value, 8'h00);
        idle(4);
        check("abort_put_count", put_rel_q.size(), 1);

        run_seq(8'h60, 1, 0, 8'h9A, 8'h00, 8'h00, 1, 0, 0);
        check("recover_puts", put_val_q.size(), 1);
        if (put_val_q.size() == 1) check("recover_put_value", put_val_q[0], 8'h9A);
        check("recover_next_addr", bus.next_addr, 8'h61);
        idle(2);

        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/operand_fetch_sequencer.md
# operand_fetch_sequencer

Sequences operand loading into the three-slot operand accumulator ahead of command issue. On a start request it fetches up to three operand bytes from instruction memory over a req/ack handshake and delivers each as a single-cycle put pulse. It then inserts the put-low cycle the accumulator needs to publish its registers, and presents a command-valid handshake to the decode/execute stage. It sits between the fetch unit, instruction memory and the accumulator.

## Interface
- ADDR_W, 8, instruction memory address width
- MAX_OPS, 3, maximum operands per command; equals accumulator slot count
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  begin a fetch sequence; sampled only in IDLE
- base_addr  in  ADDR_W  address of first operand byte; captured with start
- op_count  in  2  number of operands to load (0..3)
- mem_req  out  1  memory read request
- mem_addr  out  ADDR_W  read address, stable while mem_req=1
- mem_ack  in  1  read complete; mem_data valid in the same cycle
- mem_data  in  8  read data
- put_flag  out  1  accumulator put strobe
- put_value  out  8  operand byte to accumulator; valid when put_flag=1
- ops_loaded  out  2  operands delivered in the current sequence
- cmd_valid  out  1  accumulator outputs r0..r2 hold the command operands
- cmd_ack  in  1  consumer accepted the command
- busy  out  1  high in every state except IDLE
- next_addr  out  ADDR_W  address following the last operand fetched
- err  out  1  one-cycle pulse when start requests op_count > MAX_OPS

## Operation
- States: IDLE, REQ, PUT, SETTLE, CMD.
- IDLE → REQ: start=1 and 0 < op_count ≤ MAX_OPS. Captures base_addr into the address register, captures op_count, and clears ops_loaded.
- IDLE → SETTLE: start=1 and op_count=0.
- IDLE, start=1 and op_count > MAX_OPS: pulse err for one cycle, stay in IDLE, capture nothing.
- REQ: mem_req=1 and mem_addr=address register; hold for any number of wait cycles. On mem_ack=1, latch mem_data and go to PUT.
- PUT: put_flag=1 for exactly one cycle with put_value set to the latched byte. Increment ops_loaded and the address register.
  - Go to SETTLE if the new ops_loaded equals the captured count; otherwise go to REQ.
- SETTLE: one cycle with put_flag=0. The accumulator latches r0..r2 and clears its slot-valid flags on this edge.
- CMD: cmd_valid=1 until cmd_ack=1. On ack, go to IDLE and drive next_addr from the address register.
- Address increments wrap modulo 2^ADDR_W; no error is raised.
- Ignored inputs:
  - start when busy=1.
  - mem_ack outside REQ.
  - cmd_ack outside CMD.
- put_flag is never high in two consecutive cycles and never high in SETTLE or CMD, so slots fill strictly r0, r1, r2.
- Reset (rst_n=0 at an edge), including mid-sequence: state=IDLE; mem_req, put_flag, cmd_valid, busy and err = 0; put_value, mem_addr, next_addr and ops_loaded = 0. A pending sequence is abandoned with no further put.

## Timing
- All outputs are registered state decodes; no combinational path from inputs to outputs.
- Exception: mem_addr comes from the address register and is registered.
- Zero-wait memory (mem_ack in the first REQ cycle): cmd_valid first rises 2N+2 cycles after the start cycle, for N operands.
- Each memory wait cycle adds one cycle of latency.
- For N=0: SETTLE occupies cycle 1 and cmd_valid is high in cycle 2.
- The earliest next accepted start is the cycle after the cmd_ack cycle.
- busy rises the cycle after start and falls the cycle after cmd_ack.
- err goes high the cycle after the offending start and lasts exactly one cycle.

## Test plan
- Basic fetch: base_addr=0x10, op_count=3, memory returns 0xA1/0xB2/0xC3 with zero wait.
  - Expect puts at cycles 2, 4, 6 with put_value A1, B2, C3 and mem_addr 0x10..0x12.
  - Expect cmd_valid at cycle 8; accumulator shows r0=A1, r1=B2, r2=C3.
  - After cmd_ack, expect next_addr=0x13.
- Memory wait states: op_count=2 with mem_ack delayed 3 cycles per read.
  - Expect mem_req held and mem_addr stable throughout each wait.
  - Expect puts at cycles 5 and 10, and cmd_valid at cycle 12.
- Zero and illegal count:
  - op_count=0: expect cmd_valid at cycle 2 with no mem_req and no put.
  - Start with op_count=3 while MAX_OPS=2: expect err high for exactly one cycle, busy stays 0, no mem_req.
- Address wrap: base_addr=0xFE, op_count=3.
  - Expect mem_addr sequence 0xFE, 0xFF, 0x00 and next_addr=0x01.
- Backpressure and ignored inputs: hold cmd_ack=0 for 5 cycles.
  - Expect cmd_valid held high the whole time.
  - Pulse start mid-sequence: expect no effect.
  - Inject a spurious mem_ack in PUT: expect it ignored.
- Reset mid-sequence: drive rst_n=0 in the cycle after the first put.
  - Expect all outputs 0 on the next cycle, state IDLE, no further put_flag.
  - A new start then completes normally.
